rom_window_scheduler: RTL

- Shares the single picture ROM (addr[15:0] in, 24-bit data out, 1-cycle read latency) between two on-screen picture windows, e.g. original and gamma-corrected.
- Generates the ROM address, read enable and a window tag aligned to ROM output data.
- Accepts window position/enable updates over a valid/ready port and applies them only at frame boundaries.
- Sits between the timing generator (act_x/act_y/syncs) and the ROM/gamma/pixel-mux path.

---
 rtl/rom_window_scheduler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/rom_window_scheduler.sv
// Shares one picture ROM between two on-screen windows: hit-tests each window,
// keeps a per-window address counter and emits ROM address/enable plus a window tag aligned with ROM data.
module rom_window_scheduler #(
   parameter int X_BITS    = 12,
   parameter int Y_BITS    = 12,
   parameter int ADDR_BITS = 16,
   parameter int PIC_W     = 256,
   parameter int PIC_H     = 256,
   parameter int RD_LAT    = 1,
   parameter int VS_POL    = 1
) (
   input  logic                 pix_clk,
   input  logic                 rst,
   input  logic [X_BITS-1:0]    act_x,
   input  logic [Y_BITS-1:0]    act_y,
   input  logic                 vs_in,
   input  logic                 hs_in,
   input  logic                 de_in,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic                 cfg_win,
   input  logic                 cfg_en,
   input  logic [X_BITS-1:0]    cfg_x,
   input  logic [Y_BITS-1:0]    cfg_y,
   output logic [ADDR_BITS-1:0] rom_addr,
   output logic                 rom_en,
   output logic [1:0]           win_sel,
   output logic                 vs_out,
   output logic                 hs_out,
   output logic                 de_out
);

   localparam logic                 VsAct    = (VS_POL != 0);
   localparam logic [X_BITS:0]      PicWExt  = (X_BITS + 1)'(PIC_W);
   localparam logic [Y_BITS:0]      PicHExt  = (Y_BITS + 1)'(PIC_H);
   localparam logic [ADDR_BITS-1:0] LastAddr = ADDR_BITS'(PIC_W * PIC_H - 1);

   logic                 vsPrev_q;
   logic                 pending_q;
   logic                 pendWin_q;
   logic                 pendEn_q;
   logic [X_BITS-1:0]    pendX_q;
   logic [Y_BITS-1:0]    pendY_q;
   logic [1:0]           winEn_q;
   logic [X_BITS-1:0]    winX_q [2];
   logic [Y_BITS-1:0]    winY_q [2];
   logic [ADDR_BITS-1:0] cnt_q [2];
   logic [ADDR_BITS-1:0] cnt_d [2];
   logic [ADDR_BITS-1:0] romAddr_q;
   logic                 romEn_q;
   logic [1:0]           tagPipe_q [RD_LAT+1];
   logic [2:0]           syncPipe_q [RD_LAT+1];
   logic                 fs;
   logic [1:0]           hit;

   assign fs = (vs_in == VsAct) && (vsPrev_q != VsAct);

   // Window bounds are extended by one bit so a window near the right/bottom edge cannot wrap.
   always_comb begin
      hit = 2'b00;
      for (int w = 0; w < 2; w++) begin
         hit[w] = winEn_q[w] && de_in
                  && (act_x >= winX_q[w])
                  && ({1'b0, act_x} < ({1'b0, winX_q[w]} + PicWExt))
                  && (act_y >= winY_q[w])
                  && ({1'b0, act_y} < ({1'b0, winY_q[w]} + PicHExt));
         if (fs)
            cnt_d[w] = '0;
         else if (hit[w])
            cnt_d[w] = (cnt_q[w] == LastAddr) ? '0 : cnt_q[w] + ADDR_BITS'(1);
         else
            cnt_d[w] = cnt_q[w];
      end
   end

   // A single pending slot; it only reaches the active window registers on a frame start.
   always_ff @(posedge pix_clk) begin
      if (rst) begin
         vsPrev_q  <= VsAct;
         pending_q <= 1'b0;
         pendWin_q <= 1'b0;
         pendEn_q  <= 1'b0;
         pendX_q   <= '0;
         pendY_q   <= '0;
         winEn_q   <= 2'b00;
         for (int w = 0; w < 2; w++) begin
            winX_q[w] <= '0;
            winY_q[w] <= '0;
            cnt_q[w]  <= '0;
         end
      end else begin
         vsPrev_q <= vs_in;
         if (fs && pending_q) begin
            winEn_q[pendWin_q] <= pendEn_q;
            winX_q[pendWin_q]  <= pendX_q;
            winY_q[pendWin_q]  <= pendY_q;
            pending_q          <= 1'b0;
         end else if (cfg_valid && !pending_q) begin
            pendWin_q <= cfg_win;
            pendEn_q  <= cfg_en;
            pendX_q   <= cfg_x;
            pendY_q   <= cfg_y;
            pending_q <= 1'b1;
         end
         for (int w = 0; w < 2; w++)
            cnt_q[w] <= cnt_d[w];
      end
   end

   // Window0 owns the ROM on overlap; the tag and syncs then ride along for the ROM latency.
   always_ff @(posedge pix_clk) begin
      if (rst) begin
         romAddr_q <= '0;
         romEn_q   <= 1'b0;
         for (int i = 0; i <= RD_LAT; i++) begin
            tagPipe_q[i]  <= 2'b00;
            syncPipe_q[i] <= 3'b000;
         end
      end else begin
         if (hit[0]) begin
            romAddr_q    <= cnt_q[0];
            romEn_q      <= 1'b1;
            tagPipe_q[0] <= 2'b01;
         end else if (hit[1]) begin
            romAddr_q    <= cnt_q[1];
            romEn_q      <= 1'b1;
            tagPipe_q[0] <= 2'b10;
         end else begin
            romAddr_q    <= '0;
            romEn_q      <= 1'b0;
            tagPipe_q[0] <= 2'b00;
         end
         syncPipe_q[0] <= {vs_in, hs_in, de_in};
         for (int i = 1; i <= RD_LAT; i++) begin
            tagPipe_q[i]  <= tagPipe_q[i-1];
            syncPipe_q[i] <= syncPipe_q[i-1];
         end
      end
   end

   assign cfg_ready = !pending_q;
   assign rom_addr  = romAddr_q;
   assign rom_en    = romEn_q;
   assign win_sel   = tagPipe_q[RD_LAT];
   assign vs_out    = syncPipe_q[RD_LAT][2];
   assign hs_out    = syncPipe_q[RD_LAT][1];
   assign de_out    = syncPipe_q[RD_LAT][0];

endmodule
